// File: rtl/cfg_chain_loader_if.sv
// Word-stream handshake into cfg_chain_loader: the source (master) drives data/valid,
// and the loader (slave) returns ready.
interface cfg_chain_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cfg_chain_loader.sv
// Serialises a packed word bitstream, MSB first, into NUM_CHAINS daisy-chained config chains.
// Define CFG_CRC_EN to also check a CRC-16/CCITT trailer that follows the payload.
module cfg_chain_loader #(
  parameter int unsigned NUM_CHAINS = 3,
  parameter int unsigned CHAIN_LEN  = 64,
  parameter int unsigned WORD_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  cfg_chain_loader_if.slave     bus,
  output logic                  prgm_b,
  output logic [NUM_CHAINS-1:0] chain_en,
  output logic [NUM_CHAINS-1:0] chain_bit,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int unsigned IDX_W  = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int unsigned BIT_W  = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned WCNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef CFG_CRC_EN
    CRC,
`endif
    DONE
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   wbuf;
  logic [WCNT_W-1:0]   wcnt;
  logic [IDX_W-1:0]    chain_idx;
  logic [BIT_W-1:0]    bit_cnt;
  logic                fin;
  logic                accept;
  logic                cur_bit;

`ifdef CFG_CRC_EN
  localparam int unsigned CRC_WORDS = 16 / WORD_W;

  logic [15:0] crc;
  logic [15:0] rx;
  logic [15:0] rx_next;
  logic        rx_cnt;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign rx_next      = 16'({rx, bus.in_data});
  assign bus.in_ready = (state == LOAD && wcnt == '0 && !fin) || state == CRC;
`else
  assign bus.in_ready = state == LOAD && wcnt == '0 && !fin;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  // An accepted word bypasses the buffer so its MSB leaves on the accepting edge;
  // in_ready then only needs the buffer to be empty to sustain one bit per cycle.
  assign cur_bit = (wcnt != '0) ? wbuf[WORD_W-1] : bus.in_data[WORD_W-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wbuf      <= '0;
      wcnt      <= '0;
      chain_idx <= '0;
      bit_cnt   <= '0;
      fin       <= 1'b0;
      prgm_b    <= 1'b0;
      chain_en  <= '0;
      chain_bit <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef CFG_CRC_EN
      crc       <= '1;
      rx        <= '0;
      rx_cnt    <= 1'b0;
`endif
    end else begin
      chain_en  <= '0;
      chain_bit <= '0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            prgm_b    <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            wbuf      <= '0;
            wcnt      <= '0;
            chain_idx <= '0;
            bit_cnt   <= '0;
            fin       <= 1'b0;
`ifdef CFG_CRC_EN
            crc       <= '1;
            rx        <= '0;
            rx_cnt    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (abort) begin
            state  <= IDLE;
            err    <= 1'b1;
            prgm_b <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
          end else if (fin) begin
            prgm_b <= 1'b0;
            wcnt   <= '0;
`ifdef CFG_CRC_EN
            state  <= CRC;
`else
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
`endif
          end else if (wcnt != '0 || accept) begin
            chain_en  <= NUM_CHAINS'(1) << chain_idx;
            chain_bit <= NUM_CHAINS'(cur_bit) << chain_idx;
            if (wcnt != '0) begin
              wbuf <= wbuf << 1;
              wcnt <= wcnt - 1'b1;
            end else begin
              wbuf <= {bus.in_data[WORD_W-2:0], 1'b0};
              wcnt <= WCNT_W'(WORD_W - 1);
            end
`ifdef CFG_CRC_EN
            crc <= crc_step(crc, cur_bit);
`endif
            if (bit_cnt == BIT_W'(CHAIN_LEN - 1)) begin
              bit_cnt <= '0;
              if (chain_idx == IDX_W'(NUM_CHAINS - 1)) fin <= 1'b1;
              else                                     chain_idx <= chain_idx + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef CFG_CRC_EN
        CRC: begin
          if (abort) begin
            state <= IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (accept) begin
            rx <= rx_next;
            if (rx_cnt == 1'(CRC_WORDS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= (rx_next != crc);
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader (3 chains x 12 bits, 8-bit words); CRC steps
// are active when CFG_CRC_EN is defined.
module tb_cfg_chain_loader;
  localparam int NC = 3;
  localparam int CL = 12;
  localparam int WW = 8;
`ifdef CFG_CRC_EN
  localparam int LAG = 3;
`else
  localparam int LAG = 1;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic          prgm_b, busy, done, err;
  logic [NC-1:0] chain_en, chain_bit;

  cfg_chain_loader_if #(.WORD_W(WW)) bus ();

  cfg_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .bus(bus),
    .prgm_b(prgm_b), .chain_en(chain_en), .chain_bit(chain_bit),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WW-1:0] words [7];
  int            nw;
  logic [CL-1:0] got [NC];
  int            gcnt [NC];
  int            total, cyc, first_en, last_en, stalls, onehot_bad;
  int            start_cyc, done_cyc;
  logic          st_busy, st_err, st_prgm, d_prgm, d_err, d_busy, d_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (chain_en != '0) begin
      if ($countones(chain_en) != 1 || (chain_bit & ~chain_en) != '0) onehot_bad++;
      for (int c = 0; c < NC; c++)
        if (chain_en[c]) begin
          got[c] = {got[c][CL-2:0], chain_bit[c]};
          gcnt[c]++;
        end
      total++;
      if (first_en < 0) first_en = cyc;
      else if (cyc != last_en + 1) stalls += cyc - last_en - 1;
      last_en = cyc;
    end
  endtask

  task automatic clear_mon();
    for (int c = 0; c < NC; c++) begin
      got[c]  = '0;
      gcnt[c] = 0;
    end
    total = 0; first_en = -1; last_en = -1; stalls = 0; onehot_bad = 0; done_cyc = -1;
  endtask

  // ev_kind: 0 none, 1 abort, 2 reset, 3 start while busy; fired once total == ev_bit
  task automatic run(input int gap_word, input int gap_len, input int ev_bit,
                     input int ev_kind, input bit sa);
    int wi, gl;
    bit fired, pending, acc;
    wi = 0; gl = gap_len; fired = 0; pending = 0;
    clear_mon();
    start = 1'b1; abort = sa;
    tick();
    start = 1'b0; abort = 1'b0;
    start_cyc = cyc; st_busy = busy; st_err = err; st_prgm = prgm_b;
    for (int n = 0; n < 200; n++) begin
      if (wi < nw) begin bus.in_data = words[wi]; bus.in_valid = 1'b1; end
      else begin bus.in_data = '0; bus.in_valid = 1'b0; end
      if (wi == gap_word && gl > 0 && bus.in_ready) begin
        bus.in_valid = 1'b0;
        gl--;
      end
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) wi++;
      if (pending) begin
        pending = 0; start = 1'b0; abort = 1'b0; reset = 1'b0;
        if (ev_kind != 3) break;
      end
      if (done) begin
        done_cyc = cyc; d_prgm = prgm_b; d_err = err; d_busy = busy; d_rdy = bus.in_ready;
        break;
      end
      if (!fired && ev_kind != 0 && total == ev_bit) begin
        fired = 1; pending = 1;
        case (ev_kind)
          1: abort = 1'b1;
          2: reset = 1'b1;
          default: start = 1'b1;
        endcase
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_bits(input string tag);
    check({tag, "_total"}, total, 36);
    check({tag, "_ch0"}, got[0], 12'b101001010011);
    check({tag, "_ch1"}, got[1], 12'b110011110000);
    check({tag, "_ch2"}, got[2], 12'b000011111001);
    check({tag, "_cnt0"}, gcnt[0], 12);
    check({tag, "_onehot"}, onehot_bad, 0);
  endtask

  function automatic logic [15:0] ref_crc();
    logic [15:0] c;
    logic [WW-1:0] w;
    int n;
    c = 16'hFFFF; n = 0;
    for (int i = 0; i < 5; i++) begin
      w = words[i];
      for (int b = WW - 1; b >= 0; b--)
        if (n < 36) begin
          c = {c[14:0], 1'b0} ^ ((c[15] ^ w[b]) ? 16'h1021 : 16'h0000);
          n++;
        end
    end
    return c;
  endfunction

  initial begin
    logic [15:0] crc;
    cyc = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'h0F; words[4] = 8'h90;
    words[5] = '0; words[6] = '0;
`ifdef CFG_CRC_EN
    crc = ref_crc();
    words[5] = crc[15:8]; words[6] = crc[7:0]; nw = 7;
`else
    crc = '0; nw = 5;
`endif
    clear_mon();
    tick(); tick();
    check("rst_prgm", prgm_b, 0);
    check("rst_en", chain_en, 0);
    check("rst_bit", chain_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", bus.in_ready, 0);
    reset = 1'b0;
    tick();

    // back-to-back stream
    run(-1, 0, 0, 0, 1'b0);
    check("t1_start_prgm", st_prgm, 1);
    check("t1_start_busy", st_busy, 1);
    check_bits("t1");
    check("t1_stalls", stalls, 0);
    check("t1_first", first_en - start_cyc, 1);
    check("t1_done_cyc", done_cyc - start_cyc, 36 + LAG);
    check("t1_prgm_done", d_prgm, 0);
    check("t1_err_done", d_err, 0);
    check("t1_busy_done", d_busy, 0);
    check("t1_ready_done", d_rdy, 0);

    // abort outside a load is ignored
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort_done", done, 1);
    check("idle_abort_err", err, 0);

    // source stalls 3 cycles before word 3
    run(3, 3, 0, 0, 1'b0);
    check_bits("t2");
    check("t2_stalls", stalls, 3);
    check("t2_done_cyc", done_cyc - start_cyc, 39 + LAG);

    // abort at bit 20
    run(-1, 0, 20, 1, 1'b0);
    check("t3_total", total, 20);
    check("t3_err", err, 1);
    check("t3_done", done, 0);
    check("t3_en", chain_en, 0);
    check("t3_prgm", prgm_b, 0);
    check("t3_busy", busy, 0);
    run(-1, 0, 0, 0, 1'b0);
    check("t3_restart_err", st_err, 0);
    check_bits("t3r");
    check("t3r_err_done", d_err, 0);

    // reset at bit 7
    run(-1, 0, 7, 2, 1'b0);
    check("t4_total", total, 7);
    check("t4_outs", {prgm_b, chain_en, chain_bit, busy, done, err, bus.in_ready}, 0);
    run(-1, 0, 0, 0, 1'b0);
    check_bits("t4r");
    check("t4r_done_cyc", done_cyc - start_cyc, 36 + LAG);

    // start with abort from DONE, then start pulsed mid-load
    run(-1, 0, 15, 3, 1'b1);
    check("t5_start_wins", {st_busy, st_err}, 2'b10);
    check_bits("t5");
    check("t5_stalls", stalls, 0);
    check("t5_done_cyc", done_cyc - start_cyc, 36 + LAG);

`ifdef CFG_CRC_EN
    // corrupted trailer
    words[6] = crc[7:0] ^ 8'h01;
    run(-1, 0, 0, 0, 1'b0);
    check("t6_done", done_cyc - start_cyc, 36 + LAG);
    check("t6_err", d_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
